// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: register widths and FSM encoding shared by the
// write-back port arbiter and its holding buffer.
package wb_port_arbiter_pkg;

  localparam int REG_DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    WBA_EMPTY = 2'd0,  // nothing pending
    WBA_HELD  = 2'd1,  // one long-latency result buffered
    WBA_FORCE = 2'd2   // one-cycle pipeline stall while the buffer drains
  } wba_state_e;

  // Width of a saturating counter that must hold every value 0..max.
  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: pipeline WB, long-latency source, register-file write
// port and hazard-unit visibility, bundled for the write-back port arbiter.
interface wb_port_arbiter_if #(
  parameter int DATA_W = wb_port_arbiter_pkg::REG_DATA_WIDTH,
  parameter int ADDR_W = wb_port_arbiter_pkg::REG_ADDR_WIDTH
);
  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_rd;
  logic [DATA_W-1:0] pipe_data;
  logic              pipe_stall;
  logic              lr_valid;
  logic              lr_ready;
  logic [ADDR_W-1:0] lr_rd;
  logic [DATA_W-1:0] lr_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              buf_busy;
  logic [ADDR_W-1:0] buf_rd;

  // Arbiter side.
  modport slave (
    input  pipe_we, pipe_rd, pipe_data, lr_valid, lr_rd, lr_data,
    output pipe_stall, lr_ready, rf_we, rf_waddr, rf_wdata, buf_busy, buf_rd
  );

  // Pipeline / long-latency unit / register file side.
  modport master (
    output pipe_we, pipe_rd, pipe_data, lr_valid, lr_rd, lr_data,
    input  pipe_stall, lr_ready, rf_we, rf_waddr, rf_wdata, buf_busy, buf_rd
  );
endinterface

// File: rtl/wb_port_arbiter_hold_buf.sv
// wb_port_arbiter_hold_buf: one-entry holding register (valid, rd, data) for
// a long-latency result waiting for the register-file write port.
module wb_port_arbiter_hold_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              drop_i,
  input  logic [ADDR_W-1:0] rd_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] rd_o,
  output logic [DATA_W-1:0] data_o
);
  logic              valid_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] data_q;

  // Capture on load; drop only clears valid, rd/data are don't-care when empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      rd_q    <= rd_i;
      data_q  <= data_i;
    end else if (drop_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign rd_o    = rd_q;
  assign data_o  = data_q;
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// in-order WB path and one buffered long-latency result. The pipeline wins
// the port; the buffer drains on an idle slot or is squashed by a WAW write.
// Optional feature macro WB_ARB_STARVE_EN: after STARVE_MAX consecutive lost
// slots, stall the pipeline for one cycle to force the drain.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W     = REG_DATA_WIDTH,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);
  wba_state_e        state_q;
  logic              pipe_req, waw, lr_take;
  logic              grant_pipe, grant_buf, buf_drop;
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_rd;
  logic [DATA_W-1:0] buf_data;
  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;

`ifdef WB_ARB_STARVE_EN
  localparam int               CNT_W   = cnt_width(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // Saturating increment of the lost-arbitration count.
  always_comb begin
    starve_cnt_d = (starve_cnt_q == CNT_MAX) ? starve_cnt_q : starve_cnt_q + 1'b1;
  end
`else
  // STARVE_MAX only shapes the forced-drain logic; keep it referenced so the
  // parameter list is identical in both builds.
  if (STARVE_MAX < 0) begin : g_starve_max_unused
  end
`endif

  wb_port_arbiter_hold_buf #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .load_i (lr_take),
    .drop_i (buf_drop),
    .rd_i   (bus.lr_rd),
    .data_i (bus.lr_data),
    .valid_o(buf_valid),
    .rd_o   (buf_rd),
    .data_o (buf_data)
  );

  // Grant decode: who owns the write port this cycle and whether the buffer empties.
  always_comb begin
    pipe_req   = bus.pipe_we && (bus.pipe_rd != '0);
    waw        = pipe_req && (bus.pipe_rd == buf_rd);
    // x0 results complete the handshake but are never buffered.
    lr_take    = bus.lr_valid && (state_q == WBA_EMPTY) && (bus.lr_rd != '0);
    grant_pipe = 1'b0;
    grant_buf  = 1'b0;
    buf_drop   = 1'b0;
    case (state_q)
      WBA_EMPTY: grant_pipe = pipe_req;
      WBA_HELD: begin
        if (pipe_req) begin
          grant_pipe = 1'b1;
          buf_drop   = waw;  // newer pipeline write makes the buffered one stale
        end else begin
          grant_buf  = 1'b1;
          buf_drop   = 1'b1;
        end
      end
      WBA_FORCE: begin
        // pipe_* ignored: the stalled pipeline re-presents next cycle
        grant_buf = 1'b1;
        buf_drop  = 1'b1;
      end
      default: ;
    endcase
  end

  // FSM plus registered register-file write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= WBA_EMPTY;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
`ifdef WB_ARB_STARVE_EN
      starve_cnt_q <= '0;
`endif
    end else begin
      rf_we_q <= grant_pipe | grant_buf;
      if (grant_pipe) begin
        rf_waddr_q <= bus.pipe_rd;
        rf_wdata_q <= bus.pipe_data;
      end else if (grant_buf) begin
        rf_waddr_q <= buf_rd;
        rf_wdata_q <= buf_data;
      end
`ifdef WB_ARB_STARVE_EN
      starve_cnt_q <= '0;
`endif
      case (state_q)
        WBA_EMPTY: if (lr_take) state_q <= WBA_HELD;
        WBA_HELD: begin
          if (!pipe_req || waw) state_q <= WBA_EMPTY;
`ifdef WB_ARB_STARVE_EN
          else if (starve_cnt_d == CNT_MAX) state_q <= WBA_FORCE;
          else starve_cnt_q <= starve_cnt_d;
`endif
        end
        default: state_q <= WBA_EMPTY;  // FORCE drains in exactly one cycle
      endcase
    end
  end

  assign bus.lr_ready = (state_q == WBA_EMPTY);
`ifdef WB_ARB_STARVE_EN
  assign bus.pipe_stall = (state_q == WBA_FORCE);
`else
  assign bus.pipe_stall = 1'b0;
`endif
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.buf_busy = buf_valid;
  assign bus.buf_rd   = buf_rd;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed vector table, reset corner cases, then random
// traffic against a queue-based model of the port-sharing rules.
module tb_wb_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SM = 4;
  localparam int NV = 17;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SM)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic pwe; logic [AW-1:0] prd; logic [DW-1:0] pd;
    logic lv;  logic [AW-1:0] lrd; logic [DW-1:0] ld;
    logic ewe; logic [AW-1:0] ea;  logic [DW-1:0] ed;
    logic eb;  logic [AW-1:0] ebrd;
    logic es;  logic er;
  } vec_t;

  vec_t vt[NV];

  typedef struct { logic [AW-1:0] rd; logic [DW-1:0] d; } ent_t;
  ent_t pend[$];
  int   losses;
  bit   forcing;
  logic m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic pwe, input logic [AW-1:0] prd, input logic [DW-1:0] pd,
                        input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld);
    bus.pipe_we = pwe; bus.pipe_rd = prd; bus.pipe_data = pd;
    bus.lr_valid = lv; bus.lr_rd = lrd; bus.lr_data = ld;
  endtask

  function automatic vec_t v(input logic pwe, input logic [AW-1:0] prd, input logic [DW-1:0] pd,
                             input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                             input logic ewe, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                             input logic eb, input logic [AW-1:0] ebrd,
                             input logic es, input logic er);
    vec_t r;
    r.pwe = pwe; r.prd = prd; r.pd = pd; r.lv = lv; r.lrd = lrd; r.ld = ld;
    r.ewe = ewe; r.ea = ea; r.ed = ed; r.eb = eb; r.ebrd = ebrd; r.es = es; r.er = er;
    return r;
  endfunction

  // Reference: one cycle of the port-sharing rules applied to the model state.
  task automatic model_step(input logic pwe, input logic [AW-1:0] prd, input logic [DW-1:0] pd,
                            input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld);
    bit req;
    req  = pwe && (prd != 0);
    m_we = 1'b0;
    if (forcing) begin
      m_we = 1'b1; m_addr = pend[0].rd; m_data = pend[0].d;
      pend.delete(); forcing = 0; losses = 0;
    end else if (pend.size() == 0) begin
      if (req) begin m_we = 1'b1; m_addr = prd; m_data = pd; end
      if (lv && lrd != 0) pend.push_back('{lrd, ld});
    end else if (req) begin
      m_we = 1'b1; m_addr = prd; m_data = pd;
      if (prd == pend[0].rd) begin
        pend.delete(); losses = 0;
      end else begin
        losses++;
`ifdef WB_ARB_STARVE_EN
        if (losses >= SM) begin forcing = 1; losses = 0; end
`endif
      end
    end else begin
      m_we = 1'b1; m_addr = pend[0].rd; m_data = pend[0].d;
      pend.delete(); losses = 0;
    end
  endtask

  initial begin
    logic lv, acc;
    logic [AW-1:0] lrd;
    logic [DW-1:0] ld;

    vt[0]  = v(1, 5, 'hA5,   0, 0,  0,       1, 5,  'hA5,    0, 0,  0, 1);
    vt[1]  = v(0, 0, 0,      1, 7,  'h1234,  0, 0,  0,       1, 7,  0, 0);
    vt[2]  = v(0, 0, 0,      0, 0,  0,       1, 7,  'h1234,  0, 0,  0, 1);
    vt[3]  = v(0, 0, 0,      0, 0,  0,       0, 0,  0,       0, 0,  0, 1);
    vt[4]  = v(0, 0, 0,      1, 9,  'hDEAD,  0, 0,  0,       1, 9,  0, 0);
    vt[5]  = v(1, 9, 'h55,   0, 0,  0,       1, 9,  'h55,    0, 0,  0, 1);
    vt[6]  = v(0, 0, 0,      0, 0,  0,       0, 0,  0,       0, 0,  0, 1);
    vt[7]  = v(1, 0, 'h77,   1, 0,  'h88,    0, 0,  0,       0, 0,  0, 1);
    vt[8]  = v(0, 0, 0,      0, 0,  0,       0, 0,  0,       0, 0,  0, 1);
    vt[9]  = v(0, 0, 0,      1, 10, 'hC0DE,  0, 0,  0,       1, 10, 0, 0);
    vt[10] = v(1, 1, 'h11,   0, 0,  0,       1, 1,  'h11,    1, 10, 0, 0);
    vt[11] = v(1, 2, 'h22,   0, 0,  0,       1, 2,  'h22,    1, 10, 0, 0);
    vt[12] = v(1, 3, 'h33,   0, 0,  0,       1, 3,  'h33,    1, 10, 0, 0);
`ifdef WB_ARB_STARVE_EN
    vt[13] = v(1, 4, 'h44,   0, 0,  0,       1, 4,  'h44,    1, 10, 1, 0);
    vt[14] = v(1, 5, 'h55,   0, 0,  0,       1, 10, 'hC0DE,  0, 0,  0, 1);
    vt[15] = v(1, 5, 'h55,   0, 0,  0,       1, 5,  'h55,    0, 0,  0, 1);
`else
    vt[13] = v(1, 4, 'h44,   0, 0,  0,       1, 4,  'h44,    1, 10, 0, 0);
    vt[14] = v(1, 5, 'h55,   0, 0,  0,       1, 5,  'h55,    1, 10, 0, 0);
    vt[15] = v(0, 0, 0,      0, 0,  0,       1, 10, 'hC0DE,  0, 0,  0, 1);
`endif
    vt[16] = v(0, 0, 0,      0, 0,  0,       0, 0,  0,       0, 0,  0, 1);

    // Reset state
    set_in(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_low rf_we", bus.rf_we, 0);
    chk("rst_low buf_busy", bus.buf_busy, 0);
    rst = 1'b1;
    #1;
    chk("rst rf_waddr", bus.rf_waddr, 0);
    chk("rst rf_wdata", bus.rf_wdata, 0);
    chk("rst buf_rd", bus.buf_rd, 0);
    chk("rst pipe_stall", bus.pipe_stall, 0);
    chk("rst lr_ready", bus.lr_ready, 1);

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      set_in(vt[i].pwe, vt[i].prd, vt[i].pd, vt[i].lv, vt[i].lrd, vt[i].ld);
      @(negedge clk);
      chk($sformatf("vec%0d rf_we", i), bus.rf_we, vt[i].ewe);
      if (vt[i].ewe) begin
        chk($sformatf("vec%0d rf_waddr", i), bus.rf_waddr, vt[i].ea);
        chk($sformatf("vec%0d rf_wdata", i), bus.rf_wdata, vt[i].ed);
      end
      chk($sformatf("vec%0d buf_busy", i), bus.buf_busy, vt[i].eb);
      if (vt[i].eb) chk($sformatf("vec%0d buf_rd", i), bus.buf_rd, vt[i].ebrd);
      chk($sformatf("vec%0d pipe_stall", i), bus.pipe_stall, vt[i].es);
      chk($sformatf("vec%0d lr_ready", i), bus.lr_ready, vt[i].er);
    end

    // Reset while HELD with a write in flight
    set_in(0, 0, 0, 1, 12, 'hABC);
    @(negedge clk);
    set_in(1, 13, 'h99, 0, 0, 0);
    @(negedge clk);
    chk("midrst pre rf_we", bus.rf_we, 1);
    chk("midrst pre buf_busy", bus.buf_busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst rf_we", bus.rf_we, 0);
    chk("midrst buf_busy", bus.buf_busy, 0);
    chk("midrst pipe_stall", bus.pipe_stall, 0);
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst lr_ready", bus.lr_ready, 1);
    chk("midrst buf_busy after", bus.buf_busy, 0);

    // Random traffic against the model
    pend.delete(); losses = 0; forcing = 0; m_we = 0; m_addr = '0; m_data = '0;
    lv = 0; lrd = '0; ld = '0; acc = 0;
    for (int c = 0; c < 3000; c++) begin
      // An unaccepted long-latency result is held by its source.
      if (!(lv && !acc)) begin
        lv  = ($urandom_range(0, 2) == 0);
        lrd = AW'($urandom_range(0, 6));
        ld  = $urandom;
      end
      acc = lv && (pend.size() == 0);
      set_in($urandom_range(0, 9) < 7, AW'($urandom_range(0, 6)), $urandom, lv, lrd, ld);
      model_step(bus.pipe_we, bus.pipe_rd, bus.pipe_data, lv, lrd, ld);
      @(negedge clk);
      chk($sformatf("rnd%0d rf_we", c), bus.rf_we, m_we);
      if (m_we) begin
        chk($sformatf("rnd%0d rf_waddr", c), bus.rf_waddr, m_addr);
        chk($sformatf("rnd%0d rf_wdata", c), bus.rf_wdata, m_data);
      end
      chk($sformatf("rnd%0d buf_busy", c), bus.buf_busy, pend.size() != 0);
      if (pend.size() != 0) chk($sformatf("rnd%0d buf_rd", c), bus.buf_rd, pend[0].rd);
      chk($sformatf("rnd%0d pipe_stall", c), bus.pipe_stall, forcing);
      chk($sformatf("rnd%0d lr_ready", c), bus.lr_ready, pend.size() == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline write-back path and a long-latency result source, such as the multiply/divide unit. The block sits after the WB mux and in front of the register file, holds at most one pending long-latency result, and drains it when the pipeline slot is idle. If the pipeline keeps the port busy, the block forces a drain by stalling the pipeline for one cycle. It also squashes stale pending results on write-after-write (WAW) conflicts.

## Interface
- `DATA_W`, default `REG_DATA_WIDTH`: register data width.
- `ADDR_W`, default 5: register address width.
- `STARVE_MAX`, default 4: number of consecutive cycles a pending result may lose arbitration before a drain is forced.

- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset (0 = reset).
- `pipe_we` input 1: pipeline WB requests a write this cycle.
- `pipe_rd` input `ADDR_W`: pipeline destination register.
- `pipe_data` input `DATA_W`: pipeline write data (the WB mux output).
- `pipe_stall` output 1: tells the pipeline to hold its WB entry this cycle.
- `lr_valid` input 1: long-latency result valid.
- `lr_ready` output 1: arbiter can accept a long-latency result.
- `lr_rd` input `ADDR_W`: long-latency destination register.
- `lr_data` input `DATA_W`: long-latency result data.
- `rf_we` output 1: register-file write enable (registered).
- `rf_waddr` output `ADDR_W`: register-file write address (registered).
- `rf_wdata` output `DATA_W`: register-file write data (registered).
- `buf_busy` output 1: a long-latency result is pending (for the hazard unit).
- `buf_rd` output `ADDR_W`: destination register of the pending result.

## Operation
- FSM states:
  - EMPTY: no result pending.
  - HELD: one result buffered.
  - FORCE: one-cycle stall-and-drain.
- `lr_ready` = (state == EMPTY).
- Long-latency handshake:
  - A transfer occurs when `lr_valid` && `lr_ready`.
  - The buffer captures `lr_rd`/`lr_data` and the next state is HELD.
  - A transfer with `lr_rd` == 0 is accepted and discarded, staying in EMPTY.
- Pipeline request:
  - `pipe_req` = `pipe_we` && (`pipe_rd` != 0).
  - Writes to x0 are never issued.
- EMPTY:
  - If `pipe_req`, grant the pipeline.
- HELD:
  - If `pipe_req` and `pipe_rd` == `buf_rd` (WAW conflict): grant the pipeline, drop the buffer, go to EMPTY.
  - Else if `pipe_req`: grant the pipeline and increment `starve_cnt`.
    - If `starve_cnt` reaches `STARVE_MAX`, go to FORCE.
  - Else (pipeline slot idle): grant the buffer and go to EMPTY.
- FORCE:
  - `pipe_stall` = 1.
  - The `pipe_*` inputs are ignored; the pipeline re-presents its entry next cycle.
  - Grant the buffer and go to EMPTY.
- `starve_cnt` clears whenever the state is not HELD.
- Counter width: `$clog2(STARVE_MAX+1)`; it saturates and never wraps.
- `pipe_stall` is asserted only in FORCE.
- `lr_valid` arriving in HELD or FORCE is not accepted: `lr_ready` = 0, and the source holds its result.

## Timing
- Granted write appears on `rf_*` one cycle after the grant cycle.
- Long-latency path:
  - Minimum latency from handshake to `rf_we` is 2 cycles: capture, then grant, then the registered write.
  - After a drain, the arbiter is EMPTY and the next handshake can occur in the cycle that drain-write is visible on `rf_*`.
- Worst case from capture to drain grant, with the feature enabled: `STARVE_MAX`+1 cycles.
- `pipe_stall` and `lr_ready` are combinational from state only; there is no input-to-output combinational path.
- Reset values:
  - state EMPTY.
  - `rf_we` 0, `rf_waddr` 0, `rf_wdata` 0.
  - `buf_busy` 0, `buf_rd` 0.
  - `pipe_stall` 0, `lr_ready` 1 (after `rst` deasserts).
- Reset mid-operation: a pending result is lost, and any in-flight `rf_we` is cleared immediately (asynchronous reset).

## Configuration
- Macro: `WB_ARB_STARVE_EN`.
- Defined: starvation counter and FORCE state present, with behaviour as above.
- Undefined: no counter and no FORCE state.
  - `pipe_stall` is tied to 0.
  - The buffer drains only on an idle pipeline slot or is dropped by a WAW conflict; `STARVE_MAX` is unused.

## Structure
- Shared package / `riscv_def.v` holds:
  - the FSM state encoding `WBA_EMPTY`, `WBA_HELD`, `WBA_FORCE`;
  - `REG_DATA_WIDTH` and `REG_ADDR_WIDTH`.
- Single module. No sub-module is needed beyond an optional `wb_hold_buf` one-entry holding register (valid, rd, data), which is natural if the buffer is reused for forwarding.

## Test plan
- Pipeline-only write, `pipe_we`=1, `pipe_rd`=5, `pipe_data`=0xA5 → next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0xA5; `lr_ready` stays 1.
- Long-latency result `lr_rd`=7, data 0x1234, with the pipeline idle → capture, then `rf_we`=1, `rf_waddr`=7, `rf_wdata`=0x1234 two cycles after the handshake; `buf_busy` goes 1 then 0.
- Starvation with `STARVE_MAX`=4 and macro defined: result buffered, pipeline writes x1..x4 → `pipe_stall`=1 for exactly one cycle, buffered result written, then the held pipeline entry is written the following cycle.
- WAW conflict: buffered `rd`=9, pipeline writes `rd`=9 data 0x55 → `rf_wdata`=0x55, buffer dropped, no later write of the old data.
- Write to x0 from either source → `rf_we` never asserted; state stays EMPTY.
- Assert `rst`=0 while HELD with `rf_we`=1 → `rf_we`, `buf_busy` and `pipe_stall` are 0 immediately; after release `lr_ready`=1.
